la_capture_core: RTL and testbench
==================================

Name: la_capture_core

Overview:
- Parametrised on-chip logic-analyser capture engine, the successor to the fixed 9-probe vendor analyser instance.
- Records DATA_W probe bits per qualified sys_clk cycle into a DEPTH-entry ring buffer.
- Supports a programmable pre-trigger window and four trigger modes.
- Plays captured samples back in chronological order over a simple streaming read port, for a JTAG/UART bridge or a debug register block.

Parameters:
DATA_W, 9, probe width (1..64)
DEPTH, 256, samples stored; power of two, 16..4096
ADDR_W, $clog2(DEPTH), derived buffer address width; not to be overridden

Ports:
sys_clk  in  1  capture and readout clock
reset  in  1  synchronous, active-high reset
data_i  in  DATA_W  probe sample
sample_en  in  1  sample qualifier; 1 = capture data_i this cycle (decimation hook)
arm  in  1  single-cycle pulse; starts a new capture
abort  in  1  single-cycle pulse; returns to idle
trig_mode  in  2  0 = level match, 1 = rising, 2 = falling, 3 = any change
trig_mask  in  DATA_W  bits participating in the trigger
trig_value  in  DATA_W  level-match pattern (mode 0 only)
pretrig  in  ADDR_W  samples kept before the trigger sample
armed_o  out  1  capture in progress (PRE, WAIT or POST)
triggered_o  out  1  trigger seen in the current capture
done_o  out  1  buffer complete and readable
rd_en  in  1  request the next sample (honoured only in DONE)
rd_data  out  DATA_W  sample read out
rd_valid  out  1  rd_data valid
rd_last  out  1  marks the DEPTH-th (final) sample

Behaviour:
- Reset:
  - state = IDLE; all pointers and counters = 0.
  - All outputs = 0, including rd_data.
  - Reset mid-capture or mid-readout discards everything; no output glitches.
- States: IDLE, PRE, WAIT, POST, DONE.
- arm in IDLE or DONE:
  - Latches trig_mode, trig_mask, trig_value and pretrig into registers; later input changes are ignored until the next arm.
  - Clears wr_ptr, sample count, prev-sample valid flag and triggered_o.
  - Goes to PRE. If the latched pretrig is 0, goes straight to WAIT.
  - arm in PRE, WAIT or POST is ignored.
- abort in any non-IDLE state -> IDLE next cycle. abort has priority over arm in the same cycle.
- Sample writes:
  - Only in PRE, WAIT and POST, only when sample_en = 1.
  - Each write stores data_i at wr_ptr; wr_ptr increments modulo DEPTH.
- PRE:
  - Counts written samples.
  - When the count reaches pretrig, moves to WAIT after that write.
  - Triggers are never evaluated in PRE.
- Trigger evaluation (WAIT, qualified sample only); prev = last qualified sample:
  - Mode 0 fires when (data_i & mask) == (value & mask).
  - Mode 1 fires when |(~prev & data_i & mask).
  - Mode 2 fires when |(prev & ~data_i & mask).
  - Mode 3 fires when |((prev ^ data_i) & mask).
  - Modes 1–3 are suppressed until prev is valid, i.e. until one qualified sample has been seen since arm.
  - mask = 0 in mode 0 fires on the first WAIT sample.
  - mask = 0 in modes 1–3 never fires.
- WAIT may run indefinitely, overwriting the ring. Only the pretrig samples preceding the trigger are guaranteed kept.
- On trigger:
  - The trigger sample is written; trig_addr = its address; triggered_o = 1 next cycle.
  - Goes to POST with post_cnt = DEPTH - 1 - pretrig.
  - If post_cnt = 0, goes straight to DONE.
- POST:
  - Decrements post_cnt on each qualified write.
  - Goes to DONE after the write that takes it to 0.
- DONE:
  - done_o = 1; armed_o = 0.
  - Read pointer = (trig_addr - pretrig) mod DEPTH.
- Readout:
  - rd_en in DONE reads at the read pointer.
  - rd_data and rd_valid are asserted exactly one cycle later.
  - The pointer increments modulo DEPTH.
  - rd_last accompanies the DEPTH-th read; the next read wraps to the start address, allowing repeat dumps.
  - rd_en outside DONE is ignored (rd_valid stays 0).
  - arm and rd_en in the same cycle: arm wins; no read is issued.
- Buffer: simple dual-port, 1-cycle registered read, inferable as block RAM. No reset of memory contents.

Decomposition:
- Package la_pkg: trig_mode_e (LEVEL, RISE, FALL, CHANGE), state_e, trigger-function helper.
- Sub-module la_ring_ram: DATA_W × DEPTH simple dual-port RAM with registered read.

Test Plan:
- DEPTH=16, pretrig=4, mode 0, mask=0x1FF, value=0x055, counter ramp on data_i -> trigger at 0x055; readout = 0x051..0x060 in order; rd_last on the 16th sample.
- Mode 1, mask=0x001, data toggling bit0 every 3 cycles, pretrig=0 -> first sample read is the first 0→1 of bit0; triggered_o rises one cycle after that write.
- sample_en high every 4th cycle, ramp input -> stored samples differ by 4; trigger position is unchanged relative to qualified samples.
- abort during POST, then arm -> IDLE reached; the new capture completes correctly; arm+abort in one cycle stays in IDLE.
- Reset asserted during WAIT, and again during readout -> all outputs 0 the next cycle; a subsequent capture is correct.
- pretrig=DEPTH-1 and mode 3 with mask=0 -> DONE after trigger for the first; the second never triggers and armed_o stays 1.

Source files
------------

// File: rtl/la_pkg.sv
// Shared types and trigger evaluation for the logic-analyser capture engine.
package la_pkg;

  // Widest probe vector the trigger helper has to handle.
  localparam int unsigned TRIG_MAX_W = 64;

  typedef enum logic [1:0] {
    LEVEL  = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2,
    CHANGE = 2'd3
  } trig_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Evaluate the trigger condition for one qualified sample. Operands are
  // zero-extended, so unused upper bits never participate (mask is 0 there).
  function automatic logic trig_fire(
    input trig_mode_e            mode,
    input logic [TRIG_MAX_W-1:0] cur,
    input logic [TRIG_MAX_W-1:0] prev,
    input logic [TRIG_MAX_W-1:0] mask,
    input logic [TRIG_MAX_W-1:0] value,
    input logic                  prev_vld
  );
    logic fire;
    case (mode)
      LEVEL:   fire = ((cur & mask) == (value & mask));
      RISE:    fire = prev_vld && (|(~prev & cur & mask));
      FALL:    fire = prev_vld && (|(prev & ~cur & mask));
      CHANGE:  fire = prev_vld && (|((prev ^ cur) & mask));
      default: fire = 1'b0;
    endcase
    return fire;
  endfunction

endpackage

// File: rtl/la_ring_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
module la_ring_ram #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write port; contents are never reset so the array maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read; only the output register is cleared by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyser capture engine: pre-trigger ring capture, four trigger
// modes, chronological readout of DEPTH samples from the ring.
module la_capture_core
  import la_pkg::*;
#(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_i,
  input  logic              sample_en,
  input  logic              arm,
  input  logic              abort,
  input  logic [1:0]        trig_mode,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [ADDR_W-1:0] pretrig,
  output logic              armed_o,
  output logic              triggered_o,
  output logic              done_o,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            r_state;
  state_e            w_state_nxt;

  trig_mode_e        r_mode;
  logic [DATA_W-1:0] r_mask;
  logic [DATA_W-1:0] r_value;
  logic [ADDR_W-1:0] r_pretrig;

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_pre_cnt;
  logic [ADDR_W-1:0] r_post_cnt;
  logic [DATA_W-1:0] r_prev;
  logic              r_prev_vld;

  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_rd_cnt;

  logic              r_armed;
  logic              r_triggered;
  logic              r_done;
  logic              r_rd_valid;
  logic              r_rd_last;

  logic              w_start;
  logic              w_wr_en;
  logic              w_fire;
  logic              w_rd_go;
  logic              w_hit;
  logic [ADDR_W-1:0] w_pre_inc;
  logic [ADDR_W-1:0] w_post_init;

  assign w_pre_inc   = r_pre_cnt + ADDR_W'(1);
  assign w_post_init = LAST_IDX - r_pretrig;
  assign w_hit       = trig_fire(r_mode,
                                 TRIG_MAX_W'(data_i),
                                 TRIG_MAX_W'(r_prev),
                                 TRIG_MAX_W'(r_mask),
                                 TRIG_MAX_W'(r_value),
                                 r_prev_vld);

  // Next-state and per-cycle strobes; abort overrides everything, including arm.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_wr_en     = 1'b0;
    w_fire      = 1'b0;
    w_rd_go     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (arm) begin
          w_start     = 1'b1;
          w_state_nxt = (pretrig == '0) ? ST_WAIT : ST_PRE;
        end
      end
      ST_PRE: begin
        if (sample_en) begin
          w_wr_en = 1'b1;
          if (w_pre_inc == r_pretrig) begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (sample_en) begin
          w_wr_en = 1'b1;
          if (w_hit) begin
            w_fire      = 1'b1;
            w_state_nxt = (w_post_init == '0) ? ST_DONE : ST_POST;
          end
        end
      end
      ST_POST: begin
        if (sample_en) begin
          w_wr_en = 1'b1;
          if (r_post_cnt == ADDR_W'(1)) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (arm) begin
          w_start     = 1'b1;
          w_state_nxt = (pretrig == '0) ? ST_WAIT : ST_PRE;
        end else if (rd_en) begin
          w_rd_go = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_start     = 1'b0;
      w_wr_en     = 1'b0;
      w_fire      = 1'b0;
      w_rd_go     = 1'b0;
    end
  end

  // State register and the status flags derived from the next state.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_armed <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= (w_state_nxt == ST_PRE) || (w_state_nxt == ST_WAIT) ||
                 (w_state_nxt == ST_POST);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Capture datapath: configuration latch, write pointer, counters, trigger.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_mode      <= LEVEL;
      r_mask      <= '0;
      r_value     <= '0;
      r_pretrig   <= '0;
      r_wr_ptr    <= '0;
      r_pre_cnt   <= '0;
      r_post_cnt  <= '0;
      r_prev      <= '0;
      r_prev_vld  <= 1'b0;
      r_triggered <= 1'b0;
    end else begin
      if (w_start) begin
        r_mode      <= trig_mode_e'(trig_mode);
        r_mask      <= trig_mask;
        r_value     <= trig_value;
        r_pretrig   <= pretrig;
        r_wr_ptr    <= '0;
        r_pre_cnt   <= '0;
        r_prev_vld  <= 1'b0;
        r_triggered <= 1'b0;
      end
      if (w_wr_en) begin
        r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
        r_prev     <= data_i;
        r_prev_vld <= 1'b1;
      end
      if ((r_state == ST_PRE) && w_wr_en) begin
        r_pre_cnt <= w_pre_inc;
      end
      if (w_fire) begin
        r_triggered <= 1'b1;
        r_post_cnt  <= w_post_init;
      end else if ((r_state == ST_POST) && w_wr_en) begin
        r_post_cnt <= r_post_cnt - ADDR_W'(1);
      end
      if (abort) begin
        r_triggered <= 1'b0;
      end
    end
  end

  // Readout pointer starts pretrig entries before the trigger sample and wraps.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_rd_cnt   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_go;
      r_rd_last  <= w_rd_go && (r_rd_cnt == LAST_IDX);
      if (w_fire) begin
        r_rd_ptr <= r_wr_ptr - r_pretrig;
        r_rd_cnt <= '0;
      end else if (w_rd_go) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
        r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
      end
    end
  end

  la_ring_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (sys_clk),
    .i_rst   (reset),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_i),
    .i_re    (w_rd_go),
    .i_raddr (r_rd_ptr),
    .o_rdata (rd_data)
  );

  assign armed_o     = r_armed;
  assign triggered_o = r_triggered;
  assign done_o      = r_done;
  assign rd_valid    = r_rd_valid;
  assign rd_last     = r_rd_last;

endmodule

// File: tb/tb_la_capture_core.sv
// Bench for la_capture_core: random/directed captures against a sample-list model.
module tb_la_capture_core;

  localparam int DATA_W = 9;
  localparam int DEPTH  = 16;

  logic              sys_clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] data_i;
  logic              sample_en;
  logic              arm;
  logic              abort;
  logic [1:0]        trig_mode;
  logic [DATA_W-1:0] trig_mask;
  logic [DATA_W-1:0] trig_value;
  logic [3:0]        pretrig;
  logic              armed_o;
  logic              triggered_o;
  logic              done_o;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;

  always #5 sys_clk = ~sys_clk;

  la_capture_core #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .reset(reset), .data_i(data_i), .sample_en(sample_en),
    .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_mask(trig_mask),
    .trig_value(trig_value), .pretrig(pretrig), .armed_o(armed_o),
    .triggered_o(triggered_o), .done_o(done_o), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last)
  );

  typedef struct { int data; bit last; int cyc; } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: list of qualified samples since arm and derived readout.
  bit m_active, m_done, m_trig;
  int m_mode, m_mask, m_value, m_pre, m_tidx, m_rdi;
  int m_samp[$];
  int m_rb[DEPTH];
  int ramp = 0;
  int tcnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit fire(int mode, int cur, int prv, bit pv, int mask, int val);
    case (mode)
      0:       return ((cur ^ val) & mask) == 0;
      1:       return pv && (((~prv) & cur & mask) != 0);
      2:       return pv && ((prv & ~cur & mask) != 0);
      default: return pv && (((prv ^ cur) & mask) != 0);
    endcase
  endfunction

  // What the clock edge just did, computed from the inputs presented to it.
  task automatic model_edge();
    int n;
    if (reset) begin
      m_active = 0; m_done = 0; m_trig = 0; sb_q.delete();
      return;
    end
    if (abort) begin
      m_active = 0; m_done = 0; m_trig = 0;
      return;
    end
    if (arm && !m_active) begin
      m_mode = int'(trig_mode); m_mask = int'(trig_mask);
      m_value = int'(trig_value); m_pre = int'(pretrig);
      m_samp.delete(); m_active = 1; m_done = 0; m_trig = 0; m_tidx = -1;
      return;
    end
    if (m_done && rd_en) begin
      sb_q.push_back('{data: m_rb[m_rdi], last: (m_rdi == DEPTH - 1), cyc: cyc});
      m_rdi = (m_rdi + 1) % DEPTH;
      return;
    end
    if (m_active && sample_en) begin
      m_samp.push_back(int'(data_i));
      n = m_samp.size() - 1;
      if (!m_trig && n >= m_pre &&
          fire(m_mode, m_samp[n], (n > 0) ? m_samp[n-1] : 0, n > 0, m_mask, m_value)) begin
        m_trig = 1;
        m_tidx = n;
      end
      if (m_trig && m_samp.size() == m_tidx + DEPTH - m_pre) begin
        m_active = 0; m_done = 1; m_rdi = 0;
        for (int i = 0; i < DEPTH; i++) m_rb[i] = m_samp[m_tidx - m_pre + i];
      end
    end
  endtask

  // One clock: update the model at the edge, check status at the falling edge.
  task automatic step();
    @(posedge sys_clk);
    cyc++;
    model_edge();
    @(negedge sys_clk);
    chk("armed_o", armed_o, m_active);
    chk("done_o", done_o, m_done);
    chk("triggered_o", triggered_o, m_trig);
    if (reset) begin
      chk("rd_data_reset", rd_data, 0);
      chk("rd_last_reset", rd_last, 0);
    end
  endtask

  function automatic logic [DATA_W-1:0] gen(int kind);
    logic [DATA_W-1:0] v;
    case (kind)
      0: begin v = DATA_W'(ramp); ramp++; end
      1: begin v = {8'($urandom), 1'((tcnt / 3) % 2)}; tcnt++; end
      3: v = DATA_W'($urandom) & 9'h0FF;
      default: v = DATA_W'($urandom);
    endcase
    return v;
  endfunction

  // Arm with a configuration, then scramble the config inputs to prove latching.
  task automatic arm_cap(input int mode, input int mask, input int val, input int pre);
    trig_mode = 2'(mode); trig_mask = DATA_W'(mask);
    trig_value = DATA_W'(val); pretrig = 4'(pre);
    arm = 1'b1; rd_en = 1'($urandom_range(0, 1));
    step();
    arm = 1'b0; rd_en = 1'b0;
    trig_mode = 2'($urandom); trig_mask = DATA_W'($urandom);
    trig_value = DATA_W'($urandom); pretrig = 4'($urandom);
  endtask

  task automatic run_capture(input int kind, input int en_kind, input int limit,
                             input bit expect_done, input bit stop_trig);
    int c;
    c = 0;
    while (m_active && c < limit && !(stop_trig && m_trig)) begin
      data_i = gen(kind);
      case (en_kind)
        0:       sample_en = 1'b1;
        1:       sample_en = (c % 4 == 3);
        default: sample_en = 1'($urandom_range(0, 1));
      endcase
      rd_en = 1'($urandom_range(0, 1));
      step();
      c++;
    end
    sample_en = 1'b0; rd_en = 1'b0;
    if (expect_done) chk("done_by_budget", done_o, 1);
  endtask

  task automatic read_n(input int n, input bit gappy);
    for (int i = 0; i < n; i++) begin
      rd_en = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    rd_en = 1'b0;
  endtask

  // Scoreboard monitor: every rd_valid must match the next expected read.
  initial begin
    exp_t e;
    bit   exp_v;
    forever begin
      @(negedge sys_clk);
      exp_v = (sb_q.size() != 0) && (sb_q[0].cyc == cyc);
      if (rd_valid || exp_v) chk("rd_valid", rd_valid, exp_v);
      if (exp_v) begin
        e = sb_q.pop_front();
        if (rd_valid) begin
          chk("rd_data", rd_data, e.data);
          chk("rd_last", rd_last, e.last);
        end
      end else if (!rd_valid) begin
        chk("rd_last_idle", rd_last, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; arm = 1'b0; abort = 1'b0; sample_en = 1'b0; rd_en = 1'b0;
    data_i = '0; trig_mode = '0; trig_mask = '0; trig_value = '0; pretrig = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Level match on a ramp with pretrig 4; readout wraps for a repeat dump.
    ramp = 'h040;
    arm_cap(0, 'h1FF, 'h055, 4);
    run_capture(0, 0, 200, 1, 0);
    read_n(DEPTH + 3, 0);

    // Rising edge on bit0, no pretrigger.
    tcnt = 0;
    arm_cap(1, 'h001, 0, 0);
    run_capture(1, 0, 200, 1, 0);
    read_n(DEPTH, 0);

    // Decimated ramp: every 4th cycle qualified.
    ramp = 0;
    arm_cap(0, 'h1FF, 'h033, 5);
    run_capture(0, 1, 400, 1, 0);
    read_n(DEPTH + 8, 1);

    // Abort during POST, then arm+abort together, then a clean capture.
    arm_cap(3, 'h1FF, 0, 3);
    run_capture(2, 2, 400, 0, 1);
    sample_en = 1'b1; data_i = gen(2); step();
    data_i = gen(2); step();
    sample_en = 1'b0;
    abort = 1'b1; step(); abort = 1'b0;
    arm = 1'b1; abort = 1'b1; step(); arm = 1'b0; abort = 1'b0;
    step();
    arm_cap(3, 'h0F0, 0, 2);
    run_capture(2, 2, 400, 1, 0);
    read_n(DEPTH, 0);

    // Reset during WAIT, then during readout; captures afterwards still correct.
    arm_cap(0, 'h1FF, 'h1FF, 2);
    run_capture(3, 0, 30, 0, 0);
    reset = 1'b1; step(); reset = 1'b0; step();
    arm_cap(2, 'h1FF, 0, 6);
    run_capture(2, 0, 400, 1, 0);
    read_n(5, 0);
    reset = 1'b1; rd_en = 1'b1; step(); reset = 1'b0; rd_en = 1'b0; step();
    arm_cap(1, 'h1FF, 0, 9);
    run_capture(2, 0, 400, 1, 0);
    read_n(DEPTH + 1, 0);

    // pretrig = DEPTH-1 finishes on the trigger; mask 0 in CHANGE never fires.
    arm_cap(3, 'h1FF, 0, 15);
    run_capture(2, 0, 400, 1, 0);
    read_n(DEPTH, 0);
    arm_cap(3, 0, 0, 7);
    run_capture(2, 2, 100, 0, 0);
    chk("armed_hold", armed_o, 1);
    chk("no_trigger", triggered_o, 0);
    abort = 1'b1; step(); abort = 1'b0;

    // Randomised captures, some re-armed directly from DONE.
    for (int k = 0; k < 6; k++) begin
      int md, mk;
      md = $urandom_range(0, 3);
      mk = (md == 0) ? $urandom_range(0, 3) : $urandom_range(1, 511);
      arm_cap(md, mk, $urandom_range(0, 511), $urandom_range(0, 15));
      run_capture(2, 2, 600, 1, 0);
      read_n(DEPTH + $urandom_range(0, 4), 1);
    end

    abort = 1'b1; step(); abort = 1'b0;
    repeat (3) step();
    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
